// File: rtl/prog_freq_divider.sv
// Programmable clock divider / tick generator with glitch-free divisor reload.
// Define DIV_TAP_OUT_EN to build the free-running binary tap counter on Taps.
module prog_freq_divider #(
  parameter int WIDTH       = 20,
  parameter int DEFAULT_DIV = 2,
  parameter int NTAPS       = 20
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             Enable,
  input  logic [WIDTH-1:0] Divisor,
  input  logic             Load,
  output logic             Tick,
  output logic             ClkOut,
  output logic [WIDTH-1:0] Count,
  output logic             LoadAck,
  output logic             DivErr,
  output logic [NTAPS-1:0] Taps
);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] pdiv_q, pdiv_d;
  logic             pend_q, pend_d;
  logic             clk_q, clk_d;
  logic             tick_q, ack_q, err_q;
  logic [WIDTH-1:0] half_d;
  logic             wrap;
  logic             div_zero;

  assign div_zero = (Divisor == '0);

  always_comb begin
    wrap    = Enable && (count_q == div_q - WIDTH'(1));
    count_d = count_q;
    div_d   = div_q;
    pend_d  = pend_q;
    pdiv_d  = pdiv_q;
    if (Enable) count_d = wrap ? '0 : count_q + WIDTH'(1);
    // Apply uses the pending value from before this edge; a Load on the same
    // edge re-arms pending and is applied at the following wrap.
    if (wrap && pend_q) begin
      div_d  = pdiv_q;
      pend_d = 1'b0;
    end
    if (Load && !div_zero) begin
      pdiv_d = Divisor;
      pend_d = 1'b1;
    end
    half_d = (div_d >> 1) + {{(WIDTH-1){1'b0}}, div_d[0]};
    clk_d  = Enable ? (count_d < half_d) : clk_q;
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      count_q <= '0;
      div_q   <= WIDTH'(DEFAULT_DIV);
      pdiv_q  <= '0;
      pend_q  <= 1'b0;
      clk_q   <= 1'b1;
      tick_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      div_q   <= div_d;
      pdiv_q  <= pdiv_d;
      pend_q  <= pend_d;
      clk_q   <= clk_d;
      tick_q  <= wrap;
      ack_q   <= wrap && pend_q;
      err_q   <= Load && div_zero;
    end
  end

  assign Count   = count_q;
  assign ClkOut  = clk_q;
  assign Tick    = tick_q;
  assign LoadAck = ack_q;
  assign DivErr  = err_q;

`ifdef DIV_TAP_OUT_EN
  logic [NTAPS-1:0] taps_q;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) taps_q <= '0;
    else          taps_q <= taps_q + NTAPS'(1);
  end

  assign Taps = taps_q;
`else
  assign Taps = '0;
`endif

endmodule

// File: tb/tb_prog_freq_divider.sv
// Directed bench for prog_freq_divider (WIDTH=8, DEFAULT_DIV=2, NTAPS=4).
module tb_prog_freq_divider;
  localparam int W  = 8;
  localparam int NT = 4;

  logic          Clock = 1'b0;
  logic          Reset_n, Enable, Load;
  logic [W-1:0]  Divisor;
  logic          Tick, ClkOut, LoadAck, DivErr;
  logic [W-1:0]  Count;
  logic [NT-1:0] Taps;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  prog_freq_divider #(.WIDTH(W), .DEFAULT_DIV(2), .NTAPS(NT)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Enable(Enable), .Divisor(Divisor),
    .Load(Load), .Tick(Tick), .ClkOut(ClkOut), .Count(Count),
    .LoadAck(LoadAck), .DivErr(DivErr), .Taps(Taps)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int c, input int t,
                         input int ck, input int a, input int e);
    chk({tag, ".cnt"},  int'(Count),   c);
    chk({tag, ".tick"}, int'(Tick),    t);
    chk({tag, ".clk"},  int'(ClkOut),  ck);
    chk({tag, ".ack"},  int'(LoadAck), a);
    chk({tag, ".err"},  int'(DivErr),  e);
  endtask

  // One rising edge, then settle; tap bank is checked against edges since reset.
  task automatic step();
    @(posedge Clock);
    #1;
    cyc++;
`ifdef DIV_TAP_OUT_EN
    chk($sformatf("taps@%0d", cyc), int'(Taps), cyc % 16);
`else
    chk($sformatf("taps@%0d", cyc), int'(Taps), 0);
`endif
  endtask

  initial begin
    Reset_n = 1'b0; Enable = 1'b0; Load = 1'b0; Divisor = '0;
    #12;
    chk_out("reset", 0, 0, 1, 0, 0);
    chk("reset.taps", int'(Taps), 0);
    Reset_n = 1'b1;
    Enable  = 1'b1;

    // Default N=2: Count 1,0,1,0 ; ClkOut 0,1,0,1 ; Tick on Count returning to 0
    for (int k = 1; k <= 4; k++) begin
      step();
      chk_out($sformatf("n2_e%0d", k), k % 2, (k % 2 == 0) ? 1 : 0,
              (k % 2 == 0) ? 1 : 0, 0, 0);
    end

    // Load 5 at Count=0; applied at next wrap
    Load = 1'b1; Divisor = 8'd5;
    step(); Load = 1'b0;
    chk_out("ld5_e5", 1, 0, 0, 0, 0);
    step(); chk_out("ld5_apply", 0, 1, 1, 1, 0);
    step(); chk_out("n5_c1", 1, 0, 1, 0, 0);
    step(); chk_out("n5_c2", 2, 0, 1, 0, 0);
    step(); chk_out("n5_c3", 3, 0, 0, 0, 0);
    step(); chk_out("n5_c4", 4, 0, 0, 0, 0);
    step(); chk_out("n5_wrap", 0, 1, 1, 0, 0);

    // Load 3 then 7 before the wrap: only 7 is applied, single LoadAck
    Load = 1'b1; Divisor = 8'd3;
    step(); chk_out("ld3", 1, 0, 1, 0, 0);
    Divisor = 8'd7;
    step(); Load = 1'b0;
    chk_out("ld7", 2, 0, 1, 0, 0);
    step(); chk_out("ld7_c3", 3, 0, 0, 0, 0);
    step(); chk_out("ld7_c4", 4, 0, 0, 0, 0);
    step(); chk_out("ld7_apply", 0, 1, 1, 1, 0);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk_out($sformatf("n7_c%0d", k), k, 0, (k < 4) ? 1 : 0, 0, 0);
    end
    step(); chk_out("n7_wrap", 0, 1, 1, 0, 0);

    // Divisor 0 is rejected: DivErr one cycle, period stays 7, no LoadAck
    Load = 1'b1; Divisor = 8'd0;
    step(); Load = 1'b0;
    chk_out("ld0_err", 1, 0, 1, 0, 1);
    step(); chk_out("ld0_after", 2, 0, 1, 0, 0);
    repeat (4) step();
    chk_out("ld0_c6", 6, 0, 0, 0, 0);
    step(); chk_out("ld0_wrap", 0, 1, 1, 0, 0);

    // Back to N=5, then freeze at Count=3
    Load = 1'b1; Divisor = 8'd5;
    step(); Load = 1'b0;
    repeat (5) step();
    chk_out("re5_c6", 6, 0, 0, 0, 0);
    step(); chk_out("re5_apply", 0, 1, 1, 1, 0);
    repeat (3) step();
    chk_out("frz_at3", 3, 0, 0, 0, 0);
    Enable = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk_out($sformatf("frz_%0d", k), 3, 0, 0, 0, 0);
    end
    Enable = 1'b1;
    step(); chk_out("resume_c4", 4, 0, 0, 0, 0);
    step(); chk_out("resume_wrap", 0, 1, 1, 0, 0);

    // Async reset mid-period with a load pending
    Load = 1'b1; Divisor = 8'd3;
    step(); Load = 1'b0;
    chk_out("pre_rst", 1, 0, 1, 0, 0);
    step(); chk_out("pre_rst2", 2, 0, 1, 0, 0);
    #2 Reset_n = 1'b0;
    #1;
    chk_out("mid_rst", 0, 0, 1, 0, 0);
    chk("mid_rst.taps", int'(Taps), 0);
    #2 Reset_n = 1'b1;
    cyc = 0;
    step(); chk_out("post_rst1", 1, 0, 0, 0, 0);
    step(); chk_out("post_rst2", 0, 1, 1, 0, 0);
    step(); chk_out("post_rst3", 1, 0, 0, 0, 0);
    step(); chk_out("post_rst4", 0, 1, 1, 0, 0);

    // N=1: Tick every cycle, ClkOut stuck high
    Load = 1'b1; Divisor = 8'd1;
    step(); Load = 1'b0;
    chk_out("ld1", 1, 0, 0, 0, 0);
    step(); chk_out("ld1_apply", 0, 1, 1, 1, 0);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk_out($sformatf("n1_%0d", k), 0, 1, 1, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
